// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
package tri_bus_pkg;

  // Default number of requesters and bus width.
  localparam int DEF_NREQ = 4;
  localparam int BUS_W    = 4;

  // Width of an owner index for n requesters (at least one bit).
  function automatic int owner_w(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  localparam int OWNER_W = owner_w(DEF_NREQ);

  // Arbitration state: nobody owns the bus, or exactly one owner.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } arb_state_t;

  // Active force overlay: which bits are forced and to what value.
  typedef struct packed {
    logic [BUS_W-1:0] mask;
    logic [BUS_W-1:0] val;
  } force_t;

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Requester/force-control side of the tristate bus arbiter.
interface tri_bus_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  import tri_bus_pkg::*;

  localparam int OW = owner_w(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner_id;
  logic                  bus_busy;
  logic                  force_req;
  logic [WIDTH-1:0]      force_mask;
  logic [WIDTH-1:0]      force_val;
  logic                  release_req;
  logic                  force_ack;
  logic [WIDTH-1:0]      forced;
  logic [WIDTH-1:0]      bus_val;
  logic [WIDTH-1:0]      bus_oe;

  // Requester agents and force controller drive requests, observe results.
  modport master (
    output req, req_data, force_req, force_mask, force_val, release_req,
    input  gnt, owner_id, bus_busy, force_ack, forced, bus_val, bus_oe
  );

  // The arbiter consumes requests and produces grant and resolved bus.
  modport slave (
    input  req, req_data, force_req, force_mask, force_val, release_req,
    output gnt, owner_id, bus_busy, force_ack, forced, bus_val, bus_oe
  );

endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Round-robin search: first set request at or after i_start, with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_start,
  output logic            o_found,
  output logic [OW-1:0]   o_idx
);

  logic [OW-1:0] w_j;

  // Scan from the farthest candidate back to i_start so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = OW'((int'(i_start) + k) % NREQ);
      if (i_req[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end else begin
        o_found = o_found;
        o_idx   = o_idx;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbitration plus per-bit force overlay for a shared
// tristate bus. Produces the resolved value and drive enables that the
// downstream driver turns into the tri net.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = BUS_W,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset_l,
  tri_bus_arbiter_if.slave bus
);

  localparam int              OW       = owner_w(NREQ);
  localparam logic [3:0]      HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [OW-1:0]   LAST_ID  = OW'(NREQ - 1);

  arb_state_t      r_state, w_state_n;
  logic [NREQ-1:0] r_gnt, w_gnt_n;
  logic [OW-1:0]   r_owner, w_owner_n;
  logic [OW-1:0]   r_ptr, w_ptr_n;
  logic [3:0]      r_hold, w_hold_n;

  logic [OW-1:0]   w_after_owner;
  logic [NREQ-1:0] w_owner_mask;
  logic            w_owner_req;
  logic [NREQ-1:0] w_pick_req;
  logic [OW-1:0]   w_pick_start;
  logic            w_pick_found;
  logic [OW-1:0]   w_pick_idx;

  force_t          r_force;
  logic            r_force_ack;
  logic [WIDTH-1:0] w_base, w_base_oe;

  assign w_after_owner = (r_owner == LAST_ID) ? '0 : (r_owner + OW'(1));
  assign w_owner_mask  = NREQ'(1) << r_owner;
  assign w_owner_req   = |(bus.req & w_owner_mask);

  // Idle searches from the RR pointer; an owner hands off to the next other requester.
  always_comb begin
    w_pick_req   = bus.req;
    w_pick_start = r_ptr;
    if (r_state == S_OWNED) begin
      w_pick_req   = bus.req & ~w_owner_mask;
      w_pick_start = w_after_owner;
    end else begin
      w_pick_req   = bus.req;
      w_pick_start = r_ptr;
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_start (w_pick_start),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  // Arbitration decisions: initial grant, voluntary drop, and hold-limit hand-off.
  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_hold_n  = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_n = S_OWNED;
          w_owner_n = w_pick_idx;
          w_gnt_n   = NREQ'(1) << w_pick_idx;
          w_hold_n  = 4'd0;
        end else begin
          w_gnt_n   = '0;
          w_hold_n  = 4'd0;
        end
      end
      S_OWNED: begin
        if (!w_owner_req) begin
          // Owner let go: pass straight to the next requester, else go idle.
          w_ptr_n  = w_after_owner;
          w_hold_n = 4'd0;
          if (w_pick_found) begin
            w_owner_n = w_pick_idx;
            w_gnt_n   = NREQ'(1) << w_pick_idx;
          end else begin
            w_state_n = S_IDLE;
            w_gnt_n   = '0;
          end
        end else if ((r_hold == HOLD_MAX) && w_pick_found) begin
          // Hold budget spent and someone is waiting: rotate.
          w_ptr_n   = w_after_owner;
          w_owner_n = w_pick_idx;
          w_gnt_n   = NREQ'(1) << w_pick_idx;
          w_hold_n  = 4'd0;
        end else if (r_hold == HOLD_MAX) begin
          w_hold_n  = r_hold;
        end else begin
          w_hold_n  = r_hold + 4'd1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_gnt_n   = '0;
        w_hold_n  = 4'd0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
    end
  end

  // Force overlay: force replaces mask/value, release clears mask; force wins a tie.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_force     <= '0;
      r_force_ack <= 1'b0;
    end else if (bus.force_req) begin
      r_force.mask <= bus.force_mask;
      r_force.val  <= bus.force_val;
      r_force_ack  <= 1'b1;
    end else if (bus.release_req) begin
      r_force.mask <= '0;
      r_force_ack  <= 1'b1;
    end else begin
      r_force_ack  <= 1'b0;
    end
  end

  // Base drive comes from the owner's data slice while the bus is owned.
  always_comb begin
    w_base    = '0;
    w_base_oe = '0;
    if (r_state == S_OWNED) begin
      w_base    = bus.req_data[int'(r_owner) * WIDTH +: WIDTH];
      w_base_oe = '1;
    end else begin
      w_base    = '0;
      w_base_oe = '0;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.owner_id  = r_owner;
  assign bus.bus_busy  = (r_state == S_OWNED);
  assign bus.force_ack = r_force_ack;
  assign bus.forced    = r_force.mask;
  assign bus.bus_val   = (r_force.mask & r_force.val) | (~r_force.mask & w_base);
  assign bus.bus_oe    = r_force.mask | w_base_oe;

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter and force/release controller for one shared WIDTH-bit tristate bus.
- Grants one of NREQ requesters ownership of the bus and muxes that requester's data onto it.
- Applies a per-bit force overlay until an explicit release, modelling procedural force/release of bus slices.
- Sits between requester agents and the bus driver; the downstream driver resolves bus_val/bus_oe into the tri net.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, bus width in bits.
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while another requester is waiting (1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset_l  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester bus request, level.
- req_data  input  NREQ*WIDTH  requester data; slice i is [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, registered.
- owner_id  output  $clog2(NREQ)  index of current owner; valid when bus_busy=1.
- bus_busy  output  1  some requester owns the bus.
- force_req  input  1  one-cycle pulse: latch force_mask/force_val.
- force_mask  input  WIDTH  bits to force.
- force_val  input  WIDTH  forced values.
- release_req  input  1  one-cycle pulse: clear all forces.
- force_ack  output  1  one-cycle pulse, cycle after an accepted force_req or release_req.
- forced  output  WIDTH  currently active force mask.
- bus_val  output  WIDTH  resolved bus value.
- bus_oe  output  WIDTH  per-bit drive enable; 0 means the bit is undriven (Z at the net).

Behaviour:
- Reset (async assert, sync-released use): gnt=0, owner_id=0, bus_busy=0, forced=0, force_ack=0, bus_val=0, bus_oe=0, hold counter=0, RR pointer=0.
- FSM states:
  - IDLE: no grant.
  - OWNED: exactly one gnt bit set.
- IDLE -> OWNED:
  - Any req at edge t gives gnt at t+1.
  - Winner is the first set req at or after the RR pointer, scanning upward with wrap-around.
- OWNED, owner still requesting:
  - Hold counter increments each cycle.
  - When the counter reaches MAX_HOLD and any other req is set, the grant moves at the next edge to the next requester after the owner (RR order). The counter resets to 0.
  - With no other req set, the owner keeps the grant indefinitely and the counter saturates at MAX_HOLD.
- OWNED, owner drops req:
  - Grant is removed at the next edge.
  - If another req is set at that edge, it is granted in the same edge (no idle bubble); otherwise -> IDLE.
- RR pointer = previous owner+1 (mod NREQ), updated on every grant change.
- Grant never changes except at these decision points. gnt is always one-hot or zero.
- Base drive:
  - bus_busy=1 gives base=req_data[owner_id] and base_oe=all ones.
  - Otherwise base=0 and base_oe=0.
- Resolution (combinational from registered state):
  - bus_val = (forced & force_reg_val) | (~forced & base).
  - bus_oe = forced | base_oe.
- force_req:
  - Latches force_mask into forced and force_val into force_reg_val at the edge.
  - A force_req while already forced replaces the mask and value; it does not merge.
  - force_mask=0 is equivalent to release.
- release_req: clears forced to 0 at the edge.
- force_req and release_req in the same cycle: force_req wins, release is ignored, and a single force_ack is issued.
- Force is independent of arbitration: forced bits stay driven when the bus is IDLE, and across grant changes.
- Reset mid-operation: all grants and forces drop immediately (async). A pending force_ack is lost.

Decomposition:
- Shared package tri_bus_pkg holds:
  - localparam OWNER_W = $clog2(NREQ) helper function.
  - typedef enum logic {S_IDLE, S_OWNED} arb_state_t.
  - typedef struct for {mask, val} force_t.
- One natural sub-module: rr_pick. It is combinational: inputs req vector and start pointer, outputs a found flag and an index. It is used for both the initial grant and the hand-off.

Test Plan:
- Reset: hold reset_l=0 with req=4'b1111 -> gnt=0, bus_oe=0, forced=0; after release, gnt=4'b0001 on the first edge.
- Rotation: req=4'b0101 held, MAX_HOLD=4 -> gnt 0001 for 5 cycles, then 0100 for 5, then 0001. bus_val tracks the owner's req_data (e.g. 4'b0101 / 4'b1010).
- Back-to-back hand-off: owner 0 drops req while req[2]=1 -> gnt goes 0001 to 0100 in one edge, bus_busy never 0.
- Force overlay: bus owned with data 4'b0101; pulse force_req, mask=4'b0011, val=4'b0010 -> bus_val=4'b0110, force_ack one cycle later. release_req -> bus_val=4'b0101.
- Force while idle plus same-cycle force and release: req=0, force mask=4'b0011, val=4'b0010 -> bus_oe=4'b0011, bus_val=4'b0010. Force and release pulsed together with mask 4'b1000, val 4'b1000 -> forced=4'b1000, single force_ack.
- Async reset mid-grant with force active -> all outputs zero within the same cycle, no clock edge required.
